// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are summed CHUNK bits per
// clock through a single ripple-carry slice, with the inter-chunk carry kept
// in a register. Valid/ready handshakes on both sides; reports carry-out and
// signed overflow alongside the registered result.
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  // Datapath slice: pick the current chunk of each operand and add it with the
  // stored carry. The carry into the chunk MSB is recovered from the sum bit
  // (sum = a ^ b ^ cin), which keeps the overflow logic independent of CHUNK.
  logic [31:0]      base;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   sum_ch;
  logic             msb_cin;
  logic             last;
  logic [WIDTH-1:0] chunk_mask;
  logic [WIDTH-1:0] s_merge;

  // Chunk adder and result-chunk merge for the current counter position
  always_comb begin
    base       = 32'(cnt_q) * 32'(CHUNK);
    a_ch       = CHUNK'(a_q >> base);
    b_ch       = CHUNK'(b_q >> base);
    sum_ch     = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
    msb_cin    = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ sum_ch[CHUNK-1];
    last       = (cnt_q == CW'(NCHUNK - 1));
    chunk_mask = WIDTH'({CHUNK{1'b1}});
    s_merge    = (s_q & ~(chunk_mask << base)) | (WIDTH'(sum_ch[CHUNK-1:0]) << base);
  end

  // Next-state and next-value logic for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1, so invert b and force the carry-in.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d     = s_merge;
        carry_d = sum_ch[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          c_out_d = sum_ch[CHUNK];
          ovf_d   = msb_cin ^ sum_ch[CHUNK];
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        // Input requests are deliberately not looked at here; acceptance
        // waits for the IDLE cycle that follows the output handshake.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  // Latched operands; only meaningful after acceptance, so no reset needed
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule
